// File: rtl/stopwatch_counter.sv
// Minutes:seconds timekeeping core with run/pause control and a field-adjust
// overlay that blinks the selected field while it is being set.
module stopwatch_counter #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_hz_en,
  input  logic       two_hz_en,
  input  logic       pause_pulse,
  input  logic       sel,
  input  logic       adj,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [5:0] MAX = 6'(MAX_VAL);

  state_t     state;
  state_t     state_next;
  logic [5:0] min_next;
  logic [5:0] sec_next;
  logic       blink_phase;
  logic       blink_next;
  logic       count_tick;
  logic       adj_tick;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v);
    return (v == MAX) ? 6'd0 : v + 6'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PAUSED;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pause_pulse) state_next = (state == RUN) ? PAUSED : RUN;
  end

  always_comb begin
    running   = (state == RUN);
    blank_sec = adj & sel & blink_phase;
    blank_min = adj & ~sel & blink_phase;
  end

  // Count decision uses the pre-edge state, so a pause toggle in the same
  // cycle as a tick never changes whether that tick is counted.
  assign count_tick = !adj && (state == RUN) && one_hz_en;
  assign adj_tick   = adj && two_hz_en;

  always_comb begin
    min_next   = minutes;
    sec_next   = seconds;
    blink_next = adj ? (blink_phase ^ two_hz_en) : 1'b0;
    if (adj_tick) begin
      if (sel) sec_next = wrap_inc(seconds);
      else     min_next = wrap_inc(minutes);
    end else if (count_tick) begin
      sec_next = wrap_inc(seconds);
      if (seconds == MAX) min_next = wrap_inc(minutes);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      blink_phase <= 1'b0;
    end else begin
      minutes     <= min_next;
      seconds     <= sec_next;
      blink_phase <= blink_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: counting, wrap/carry, adjust overlay,
// blink flags, same-cycle pause/tick ordering and asynchronous reset.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       one_hz_en;
  logic       two_hz_en;
  logic       pause_pulse;
  logic       sel;
  logic       adj;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       blank_min;
  logic       blank_sec;

  int passed = 0;
  int total  = 0;

  stopwatch_counter #(.MAX_VAL(59)) dut (
    .clk        (clk),
    .rst        (rst),
    .one_hz_en  (one_hz_en),
    .two_hz_en  (two_hz_en),
    .pause_pulse(pause_pulse),
    .sel        (sel),
    .adj        (adj),
    .minutes    (minutes),
    .seconds    (seconds),
    .running    (running),
    .blank_min  (blank_min),
    .blank_sec  (blank_sec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock cycle with the given single-cycle pulses; returns #1 after the edge.
  task automatic step(input logic p, input logic o, input logic t);
    pause_pulse = p;
    one_hz_en   = o;
    two_hz_en   = t;
    @(posedge clk);
    #1;
    pause_pulse = 1'b0;
    one_hz_en   = 1'b0;
    two_hz_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; one_hz_en = 1'b0; two_hz_en = 1'b0;
    pause_pulse = 1'b0; sel = 1'b0; adj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_min", 8'(minutes), 8'd0);
    chk("rst_sec", 8'(seconds), 8'd0);
    chk("rst_run", 8'(running), 8'd0);
    chk("rst_bmin", 8'(blank_min), 8'd0);
    chk("rst_bsec", 8'(blank_sec), 8'd0);
    rst = 1'b0;

    // Start and count 61 ticks.
    step(1, 0, 0);
    chk("start_run", 8'(running), 8'd1);
    for (int i = 0; i < 61; i++) step(0, 1, 0);
    chk("cnt61_min", 8'(minutes), 8'd1);
    chk("cnt61_sec", 8'(seconds), 8'd1);
    chk("cnt61_run", 8'(running), 8'd1);

    // Pause, preload 59:58 via adjust (115 toggles -> blink phase 1).
    step(1, 0, 0);
    chk("pause_run", 8'(running), 8'd0);
    adj = 1'b1; sel = 1'b0;
    for (int i = 0; i < 58; i++) step(0, 0, 1);
    sel = 1'b1;
    for (int i = 0; i < 57; i++) step(0, 0, 1);
    chk("pre_min", 8'(minutes), 8'd59);
    chk("pre_sec", 8'(seconds), 8'd58);
    chk("pre_bsec", 8'(blank_sec), 8'd1);
    chk("pre_bmin", 8'(blank_min), 8'd0);
    adj = 1'b0;
    #1;
    chk("noadj_bsec", 8'(blank_sec), 8'd0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("wrap1_min", 8'(minutes), 8'd59);
    chk("wrap1_sec", 8'(seconds), 8'd59);
    step(0, 1, 0);
    chk("wrap2_min", 8'(minutes), 8'd0);
    chk("wrap2_sec", 8'(seconds), 8'd0);

    // Adjust in RUN: seconds 0->59, minutes 0->5 (64 toggles -> phase 0).
    adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < 59; i++) step(0, 0, 1);
    sel = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    sel = 1'b1;
    #1;
    chk("ph0_bsec", 8'(blank_sec), 8'd0);
    step(0, 0, 1);
    chk("nocarry_sec", 8'(seconds), 8'd0);
    chk("nocarry_min", 8'(minutes), 8'd5);
    chk("nocarry_bsec", 8'(blank_sec), 8'd1);
    chk("nocarry_bmin", 8'(blank_min), 8'd0);

    // Minutes adjust while RUN: 5 one_hz ignored, 3 two_hz increments.
    sel = 1'b0;
    #1;
    chk("selmin_bmin", 8'(blank_min), 8'd1);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("adjrun_min", 8'(minutes), 8'd8);
    chk("adjrun_sec", 8'(seconds), 8'd0);
    chk("adjrun_bmin", 8'(blank_min), 8'd0);
    chk("adjrun_run", 8'(running), 8'd1);
    adj = 1'b0;
    step(0, 1, 0);
    chk("resume_sec", 8'(seconds), 8'd1);
    chk("resume_min", 8'(minutes), 8'd8);

    // Same-cycle pause + tick from PAUSED, then from RUN.
    step(1, 0, 0);
    chk("sc_paused", 8'(running), 8'd0);
    step(1, 1, 0);
    chk("sc_p_run", 8'(running), 8'd1);
    chk("sc_p_sec", 8'(seconds), 8'd1);
    step(1, 1, 0);
    chk("sc_r_run", 8'(running), 8'd0);
    chk("sc_r_sec", 8'(seconds), 8'd2);

    // One more counted tick, then preload 12:34 (35 toggles -> phase 1).
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("pre2_sec", 8'(seconds), 8'd3);
    adj = 1'b1; sel = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    sel = 1'b1;
    for (int i = 0; i < 31; i++) step(0, 0, 1);
    step(1, 0, 0);
    chk("pre2_min", 8'(minutes), 8'd12);
    chk("pre2_sec2", 8'(seconds), 8'd34);
    chk("pre2_run", 8'(running), 8'd1);
    chk("pre2_bsec", 8'(blank_sec), 8'd1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_min", 8'(minutes), 8'd0);
    chk("arst_sec", 8'(seconds), 8'd0);
    chk("arst_run", 8'(running), 8'd0);
    chk("arst_bsec", 8'(blank_sec), 8'd0);
    chk("arst_bmin", 8'(blank_min), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    adj = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
